alarm_controller: RTL and testbench

Alarm stage directly downstream of the 0-23 hour counter and the 0-59 minute counter. It holds a user-set alarm time, compares it against the live HOUR/MINUTE counts, and drives the buzzer. It also handles snooze, stop, auto-timeout and disarm. All timing is counted in minute ticks supplied by the timebase, so the block needs no clock-frequency parameter.

---
 rtl/alarm_controller.sv | 133 +++++++++++++
 tb/tb_alarm_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm stage behind the hour/minute counters: holds the alarm setpoint, fires once per
// matching minute, and sequences ringing, snooze, stop and auto-timeout in minute ticks.
module alarm_controller #(
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 5,
  parameter int unsigned MAX_SNOOZE       = 3
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic [4:0] HOUR,
  input  logic [5:0] MINUTE,
  input  logic       Min_Tick,
  input  logic       Alarm_En,
  input  logic       Set_Alarm,
  input  logic       Hr_Up,
  input  logic       Min_Up,
  input  logic       Snooze,
  input  logic       Stop,
  output logic [4:0] ALM_HOUR,
  output logic [5:0] ALM_MIN,
  output logic       BUZZ,
  output logic [1:0] STATE,
  output logic [1:0] SNZ_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_RINGING = 2'b10,
    ST_SNOOZE  = 2'b11
  } state_t;

  localparam logic [3:0] SNZ_LD  = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_TO = 4'(RING_TIMEOUT_MIN);
  localparam logic [1:0] SNZ_MAX = 2'(MAX_SNOOZE);

  state_t     state, state_nx;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;
  logic       match, match_d, trigger;
  logic [3:0] ring_tmr, ring_nx;
  logic [3:0] snz_tmr, snz_tmr_nx;
  logic [1:0] snz_cnt, snz_cnt_nx;

  // ALM_HOUR never exceeds 23, so out-of-range HOUR values cannot match
  assign match   = (HOUR == alm_hour) && (MINUTE == alm_min);
  assign trigger = match && !match_d;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      alm_hour <= '0;
      alm_min  <= '0;
    end else if (Set_Alarm) begin
      if (Hr_Up)  alm_hour <= (alm_hour == 5'd23) ? 5'd0 : alm_hour + 5'd1;
      if (Min_Up) alm_min  <= (alm_min  == 6'd59) ? 6'd0 : alm_min  + 6'd1;
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state    <= ST_IDLE;
      match_d  <= 1'b0;
      ring_tmr <= '0;
      snz_tmr  <= '0;
      snz_cnt  <= '0;
    end else begin
      state    <= state_nx;
      match_d  <= match;
      ring_tmr <= ring_nx;
      snz_tmr  <= snz_tmr_nx;
      snz_cnt  <= snz_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    ring_nx    = ring_tmr;
    snz_tmr_nx = snz_tmr;
    snz_cnt_nx = snz_cnt;
    if (Set_Alarm || !Alarm_En) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_ARMED;
        ST_ARMED: begin
          if (trigger) begin
            state_nx = ST_RINGING;
            ring_nx  = '0;
          end
        end
        ST_RINGING: begin
          // Stop/Snooze transitions consume any coincident Min_Tick
          if (Stop) begin
            state_nx = ST_ARMED;
          end else if (Snooze && (snz_cnt < SNZ_MAX)) begin
            state_nx   = ST_SNOOZE;
            snz_tmr_nx = SNZ_LD;
            snz_cnt_nx = snz_cnt + 2'd1;
          end else if (Min_Tick) begin
            if (ring_tmr + 4'd1 >= RING_TO) state_nx = ST_ARMED;
            else                            ring_nx  = ring_tmr + 4'd1;
          end
        end
        ST_SNOOZE: begin
          if (Stop) begin
            state_nx = ST_ARMED;
          end else if (Min_Tick) begin
            if (snz_tmr <= 4'd1) begin
              state_nx = ST_RINGING;
              ring_nx  = '0;
            end else begin
              snz_tmr_nx = snz_tmr - 4'd1;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
    // A new alarm event starts from clean counters
    if (state_nx == ST_IDLE || state_nx == ST_ARMED) begin
      ring_nx    = '0;
      snz_tmr_nx = '0;
      snz_cnt_nx = '0;
    end
  end

  assign ALM_HOUR = alm_hour;
  assign ALM_MIN  = alm_min;
  assign STATE    = state;
  assign BUZZ     = (state == ST_RINGING);
  assign SNZ_CNT  = snz_cnt;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: expected {STATE,BUZZ,SNZ_CNT,ALM_HOUR,ALM_MIN}
// words are queued with each stimulus and compared after the following clock edge.
module tb_alarm_controller;

  logic       Clk, Clr;
  logic [4:0] HOUR;
  logic [5:0] MINUTE;
  logic       Min_Tick, Alarm_En, Set_Alarm, Hr_Up, Min_Up, Snooze, Stop;
  logic [4:0] ALM_HOUR;
  logic [5:0] ALM_MIN;
  logic       BUZZ;
  logic [1:0] STATE, SNZ_CNT;

  alarm_controller dut (
    .Clk(Clk), .Clr(Clr), .HOUR(HOUR), .MINUTE(MINUTE), .Min_Tick(Min_Tick),
    .Alarm_En(Alarm_En), .Set_Alarm(Set_Alarm), .Hr_Up(Hr_Up), .Min_Up(Min_Up),
    .Snooze(Snooze), .Stop(Stop), .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN),
    .BUZZ(BUZZ), .STATE(STATE), .SNZ_CNT(SNZ_CNT)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t         sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] obs;
  assign obs = {STATE, BUZZ, SNZ_CNT, ALM_HOUR, ALM_MIN};

  function automatic logic [15:0] pk(logic [1:0] st, logic bz, logic [1:0] sc,
                                     logic [4:0] h, logic [5:0] m);
    return {st, bz, sc, h, m};
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got st=%b bz=%b snz=%0d alm=%0d:%0d exp st=%b bz=%b snz=%0d alm=%0d:%0d",
               tag, got[15:14], got[13], got[12:11], got[10:6], got[5:0],
               exp[15:14], exp[13], exp[12:11], exp[10:6], exp[5:0]);
    end
  endtask

  task automatic expect_st(string tag, logic [15:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic drain();
    sb_t ent;
    while (sb.size() > 0) begin
      ent = sb.pop_front();
      chk(ent.tag, obs, ent.exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    drain();
  endtask

  // Re-arm the match edge at 07:30 and ring: leave the minute, come back
  task automatic ring_up(string tag);
    MINUTE = 6'd31;
    expect_st({tag, "_leave"}, pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
    tick();
    MINUTE = 6'd30;
    expect_st({tag, "_ring"}, pk(2'b10, 1'b1, 2'd0, 5'd7, 6'd30));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish got timeout exp finish");
    $fatal(1);
  end

  initial begin
    Clr = 1'b0; HOUR = 5'd12; MINUTE = 6'd0; Min_Tick = 0; Alarm_En = 0;
    Set_Alarm = 0; Hr_Up = 0; Min_Up = 0; Snooze = 0; Stop = 0;
    #3;
    expect_st("reset", pk(2'b00, 1'b0, 2'd0, 5'd0, 6'd0));
    drain();
    #9 Clr = 1'b1;

    // setpoint edit: hour wrap, minute wrap without carry, simultaneous ups
    Set_Alarm = 1; Hr_Up = 1;
    for (int i = 0; i < 24; i++) begin
      expect_st($sformatf("hr_up%0d", i), pk(2'b00, 1'b0, 2'd0, 5'((i + 1) % 24), 6'd0));
      tick();
    end
    Hr_Up = 0; Min_Up = 1;
    for (int i = 0; i < 61; i++) begin
      expect_st($sformatf("min_up%0d", i), pk(2'b00, 1'b0, 2'd0, 5'd0, 6'((i + 1) % 60)));
      tick();
    end
    for (int i = 0; i < 29; i++) begin
      Hr_Up = (i < 7);
      expect_st($sformatf("both_up%0d", i),
                pk(2'b00, 1'b0, 2'd0, (i < 7) ? 5'(i + 1) : 5'd7, 6'(i + 2)));
      tick();
    end
    Set_Alarm = 0; Hr_Up = 1; Min_Up = 1;
    expect_st("up_ignored", pk(2'b00, 1'b0, 2'd0, 5'd7, 6'd30));
    tick();
    Hr_Up = 0; Min_Up = 0;

    // arm at 07:29, ring on 07:30 with one edge of latency, then stop
    HOUR = 5'd7; MINUTE = 6'd29; Alarm_En = 1;
    expect_st("armed", pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
    tick();
    MINUTE = 6'd30;
    #1;
    expect_st("pre_edge", pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
    drain();
    expect_st("ring", pk(2'b10, 1'b1, 2'd0, 5'd7, 6'd30));
    tick();
    Stop = 1;
    expect_st("stop", pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
    tick();
    Stop = 0;
    for (int i = 0; i < 3; i++) begin
      expect_st($sformatf("no_rering%0d", i), pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
      tick();
    end

    // three snooze rounds; first snooze carries a Min_Tick that must not count
    ring_up("snz");
    for (int r = 1; r <= 3; r++) begin
      Snooze = 1; Min_Tick = (r == 1);
      expect_st($sformatf("snooze%0d", r), pk(2'b11, 1'b0, 2'(r), 5'd7, 6'd30));
      tick();
      Snooze = 0; Min_Tick = 0;
      if (r == 2) begin
        Snooze = 1;
        expect_st("snooze_in_snooze", pk(2'b11, 1'b0, 2'd2, 5'd7, 6'd30));
        tick();
        Snooze = 0;
      end
      for (int k = 1; k <= 9; k++) begin
        Min_Tick = 1;
        expect_st($sformatf("snz%0d_tick%0d", r, k),
                  (k < 9) ? pk(2'b11, 1'b0, 2'(r), 5'd7, 6'd30)
                          : pk(2'b10, 1'b1, 2'(r), 5'd7, 6'd30));
        tick();
      end
      Min_Tick = 0;
    end
    Snooze = 1;
    expect_st("snooze_sat", pk(2'b10, 1'b1, 2'd3, 5'd7, 6'd30));
    tick();
    Snooze = 0;
    for (int k = 1; k <= 5; k++) begin
      Min_Tick = 1;
      expect_st($sformatf("to_after_snz%0d", k),
                (k < 5) ? pk(2'b10, 1'b1, 2'd3, 5'd7, 6'd30)
                        : pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
      tick();
    end
    Min_Tick = 0;

    // fresh ring, auto-timeout with gapped minute ticks
    ring_up("to");
    for (int k = 1; k <= 5; k++) begin
      Min_Tick = 1;
      expect_st($sformatf("timeout%0d", k),
                (k < 5) ? pk(2'b10, 1'b1, 2'd0, 5'd7, 6'd30)
                        : pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
      tick();
      Min_Tick = 0;
      expect_st($sformatf("timeout_gap%0d", k),
                (k < 5) ? pk(2'b10, 1'b1, 2'd0, 5'd7, 6'd30)
                        : pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
      tick();
    end

    // Stop beats Snooze; Set_Alarm overrides ringing
    ring_up("ss");
    Stop = 1; Snooze = 1;
    expect_st("stop_snooze", pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
    tick();
    Stop = 0; Snooze = 0;
    ring_up("set");
    Set_Alarm = 1;
    expect_st("set_override", pk(2'b00, 1'b0, 2'd0, 5'd7, 6'd30));
    tick();
    Set_Alarm = 0;
    for (int i = 0; i < 3; i++) begin
      expect_st($sformatf("rearm_in_match%0d", i), pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
      tick();
    end
    Alarm_En = 0;
    expect_st("disarm", pk(2'b00, 1'b0, 2'd0, 5'd7, 6'd30));
    tick();
    Alarm_En = 1;
    for (int i = 0; i < 3; i++) begin
      expect_st($sformatf("arm_in_match%0d", i), pk(2'b01, 1'b0, 2'd0, 5'd7, 6'd30));
      tick();
    end

    // asynchronous reset while snoozing
    ring_up("arst");
    Snooze = 1;
    expect_st("arst_snooze", pk(2'b11, 1'b0, 2'd1, 5'd7, 6'd30));
    tick();
    Snooze = 0;
    #2 Clr = 1'b0;
    #1;
    expect_st("async_rst", pk(2'b00, 1'b0, 2'd0, 5'd0, 6'd0));
    drain();
    Alarm_En = 0;
    #3 Clr = 1'b1;
    expect_st("post_rst", pk(2'b00, 1'b0, 2'd0, 5'd0, 6'd0));
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
